// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, bit-serial shifts and an
// optional iterative shift-add multiplier enabled by `define ALU_MC_MUL_EN.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             fZ,
    output logic             fC,
    output logic             fN,
    output logic             fE,
    output logic             fV
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORR = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_LSL = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_SBC = 4'd9;
`ifdef ALU_MC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;
`endif
    localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef ALU_MC_MUL_EN
        S_MUL   = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [SHW:0]     r_cnt;
    logic             r_lsl;
`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] r_hi, r_lo, r_mcand;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
`endif
    logic [WIDTH:0]   w_add, w_sub;
    logic             w_cin, w_is_shift, w_multi;
    logic [SHW-1:0]   w_n;
    logic [WIDTH-1:0] w_res, w_sh_next, w_fin_o;
    logic             w_res_c, w_res_v, w_sh_out, w_fin, w_fin_c, w_fin_v;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    // Single-cycle result from the live inputs, used when an op finishes straight from IDLE
    always_comb begin
        w_cin      = ((op == OP_ADC) || (op == OP_SBC)) ? fC : 1'b0;
        w_add      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
        w_sub      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};
        w_n        = b[SHW-1:0];
        w_is_shift = (op == OP_LSR) || (op == OP_LSL);
`ifdef ALU_MC_MUL_EN
        w_multi    = (w_is_shift && (w_n != {SHW{1'b0}})) || (op == OP_MUL);
`else
        w_multi    = w_is_shift && (w_n != {SHW{1'b0}});
`endif
        w_res   = {WIDTH{1'b0}};
        w_res_c = 1'b0;
        w_res_v = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                w_res   = w_add[WIDTH-1:0];
                w_res_c = w_add[WIDTH];
                w_res_v = add_ovf(a[WIDTH-1], b[WIDTH-1], w_add[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                w_res   = w_sub[WIDTH-1:0];
                w_res_c = w_sub[WIDTH];
                w_res_v = sub_ovf(a[WIDTH-1], b[WIDTH-1], w_sub[WIDTH-1]);
            end
            OP_AND:         w_res = a & b;
            OP_ORR:         w_res = a | b;
            OP_NOT:         w_res = ~a;
            OP_XOR:         w_res = a ^ b;
            // a zero-amount shift passes the operand through untouched
            OP_LSR, OP_LSL: w_res = a;
            default:        w_res = {WIDTH{1'b0}};
        endcase
    end

    // One bit of shift per cycle; the carry is the bit falling off the end
    always_comb begin
        if (r_lsl) begin
            w_sh_next = {r_acc[WIDTH-2:0], 1'b0};
            w_sh_out  = r_acc[WIDTH-1];
        end else begin
            w_sh_next = {1'b0, r_acc[WIDTH-1:1]};
            w_sh_out  = r_acc[0];
        end
    end

`ifdef ALU_MC_MUL_EN
    // Shift-add step: {hi,lo} ends as the full product once every multiplier bit in lo is consumed
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
`endif

    // Select the value latched into o/flags on the edge that enters DONE
    always_comb begin
        w_fin   = 1'b0;
        w_fin_o = w_res;
        w_fin_c = w_res_c;
        w_fin_v = w_res_v;
        case (r_state)
            S_IDLE: begin
                if (start && !w_multi) w_fin = 1'b1;
                else                   w_fin = 1'b0;
            end
            S_SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_fin   = 1'b1;
                    w_fin_o = w_sh_next;
                    w_fin_c = w_sh_out;
                    w_fin_v = 1'b0;
                end else begin
                    w_fin = 1'b0;
                end
            end
`ifdef ALU_MC_MUL_EN
            S_MUL: begin
                if (r_cnt == CNT_ONE) begin
                    w_fin   = 1'b1;
                    w_fin_o = w_mul_lo;
                    w_fin_c = |w_mul_hi;
                    w_fin_v = |w_mul_hi;
                end else begin
                    w_fin = 1'b0;
                end
            end
`endif
            default: w_fin = 1'b0;
        endcase
    end

    // Control FSM plus the registered result, flags and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= {WIDTH{1'b0}};
            r_cnt   <= {(SHW+1){1'b0}};
            r_lsl   <= 1'b0;
`ifdef ALU_MC_MUL_EN
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
            r_mcand <= {WIDTH{1'b0}};
`endif
            busy    <= 1'b0;
            done    <= 1'b0;
            o       <= {WIDTH{1'b0}};
            fZ      <= 1'b1;
            fE      <= 1'b1;
            fC      <= 1'b0;
            fN      <= 1'b0;
            fV      <= 1'b0;
        end else begin
            done <= w_fin;
            if (w_fin) begin
                o  <= w_fin_o;
                fZ <= (w_fin_o == {WIDTH{1'b0}});
                fN <= w_fin_o[WIDTH-1];
                fE <= ~w_fin_o[0];
                fC <= w_fin_c;
                fV <= w_fin_v;
            end else begin
                o <= o;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (w_is_shift && (w_n != {SHW{1'b0}})) begin
                            r_state <= S_SHIFT;
                            r_acc   <= a;
                            r_cnt   <= {1'b0, w_n};
                            r_lsl   <= (op == OP_LSL);
                        end
`ifdef ALU_MC_MUL_EN
                        else if (op == OP_MUL) begin
                            r_state <= S_MUL;
                            r_hi    <= {WIDTH{1'b0}};
                            r_lo    <= b;
                            r_mcand <= a;
                            r_cnt   <= (SHW+1)'(WIDTH);
                        end
`endif
                        else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_sh_next;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) r_state <= S_DONE;
                    else                  r_state <= S_SHIFT;
                end
`ifdef ALU_MC_MUL_EN
                S_MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) r_state <= S_DONE;
                    else                  r_state <= S_MUL;
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16): behavioural model compared every
// cycle, plus hand-computed literal checks on directed vectors.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  op;
    logic [15:0] a, b, o;
    logic        busy, done, fZ, fC, fN, fE, fV;

    int checks   = 0;
    int failures = 0;

    // model state: expected outputs after each rising edge
    int          m_left = 0;
    logic [15:0] e_o = 16'h0, p_o = 16'h0;
    logic        e_fz = 1'b1, e_fc = 1'b0, e_fn = 1'b0, e_fe = 1'b1, e_fv = 1'b0;
    logic        p_fc = 1'b0, p_fv = 1'b0;

    alu_mc #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .o(o),
        .fZ(fZ), .fC(fC), .fN(fN), .fE(fE), .fV(fV)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Result, carry, overflow and latency of one operation, from plain arithmetic
    task automatic model(input logic [3:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                         input logic cin, output logic [15:0] r, output logic c,
                         output logic v, output int lat);
        int unsigned ua, ub, s, bw;
        longint unsigned p;
        int n;
        ua = ma; ub = mb; r = 16'h0; c = 1'b0; v = 1'b0; lat = 1; n = mb[3:0];
        case (mop)
            4'd0, 4'd8: begin
                s = ua + ub + ((mop == 4'd8) ? 32'(cin) : 32'd0);
                r = s[15:0]; c = s[16];
                v = (ma[15] == mb[15]) && (r[15] != ma[15]);
            end
            4'd1, 4'd9: begin
                bw = ub + ((mop == 4'd9) ? 32'(cin) : 32'd0);
                s = ua - bw; r = s[15:0]; c = (ua < bw);
                v = (ma[15] != mb[15]) && (r[15] != ma[15]);
            end
            4'd2: r = ma & mb;
            4'd3: r = ma | mb;
            4'd4: r = ~ma;
            4'd5: r = ma ^ mb;
            4'd6: begin r = ma >> n; if (n > 0) c = ma[n-1]; lat = n + 1; end
            4'd7: begin r = ma << n; if (n > 0) c = ma[16-n]; lat = n + 1; end
`ifdef ALU_MC_MUL_EN
            4'd10: begin
                p = longint'(ua) * longint'(ub);
                r = p[15:0]; c = ((p >> 16) != 0); v = c; lat = 17;
            end
`endif
            default: r = 16'h0;
        endcase
    endtask

    // Model update on each rising edge, then compare all outputs 1 time unit later
    initial begin
        logic [15:0] r;
        logic c, v;
        int lat;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_left = 0; e_o = 16'h0; e_fz = 1'b1; e_fe = 1'b1;
                e_fc = 1'b0; e_fn = 1'b0; e_fv = 1'b0;
            end else begin
                if (m_left != 0) m_left--;
                else if (start) begin
                    model(op, a, b, e_fc, r, c, v, lat);
                    p_o = r; p_fc = c; p_fv = v; m_left = lat;
                end
                if (m_left == 1) begin
                    e_o = p_o; e_fz = (p_o == 16'h0); e_fn = p_o[15]; e_fe = ~p_o[0];
                    e_fc = p_fc; e_fv = p_fv;
                end
            end
            #1;
            check("cyc_busy", busy, (m_left != 0));
            check("cyc_done", done, (m_left == 1));
            check("cyc_o", o, e_o);
            check("cyc_flags", {fZ, fC, fN, fE, fV}, {e_fz, e_fc, e_fn, e_fe, e_fv});
        end
    end

    // Issue one op; optionally re-pulse start at cycle 'poke' while busy
    task automatic do_op(input logic [3:0] vop, input logic [15:0] va, input logic [15:0] vb,
                         input int poke, output int lat, output int bcnt);
        @(negedge clk); op = vop; a = va; b = vb; start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 1; bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            start = (lat == poke);
            @(negedge clk); lat++;
        end
        start = 1'b0;
        if (busy === 1'b1) bcnt++;
        check("done_seen", done, 1'b1);
    endtask

    initial begin
        int lat, bcnt, dcnt;
        rst = 1'b1; start = 1'b0; op = 4'd0; a = 16'h0; b = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_o", o, 16'h0);
        check("rst_flags", {fZ, fC, fN, fE, fV}, 5'b10010);
        check("rst_busy_done", {busy, done}, 2'b00);

        do_op(4'd0, 16'h7FFF, 16'h0001, 0, lat, bcnt);
        check("add_lat", lat, 1);
        check("add_o", o, 16'h8000);
        check("add_flags", {fZ, fC, fN, fE, fV}, 5'b00111);

        do_op(4'd1, 16'h0000, 16'h0001, 0, lat, bcnt);
        check("sub_o", o, 16'hFFFF);
        check("sub_flags", {fZ, fC, fN, fE, fV}, 5'b01100);
        do_op(4'd8, 16'h0001, 16'h0001, 0, lat, bcnt);
        check("adc_o", o, 16'h0003);
        check("adc_fc", fC, 1'b0);

        do_op(4'd7, 16'h8001, 16'h0004, 2, lat, bcnt);
        check("lsl_lat", lat, 5);
        check("lsl_busy_cycles", bcnt, 5);
        check("lsl_o", o, 16'h0010);
        check("lsl_flags", {fZ, fC, fN, fE, fV}, 5'b00010);

        do_op(4'd6, 16'h8001, 16'h0001, 0, lat, bcnt);
        check("lsr1_lat", lat, 2);
        check("lsr1_o", o, 16'h4000);
        check("lsr1_fc", fC, 1'b1);
        do_op(4'd6, 16'h1234, 16'h0010, 0, lat, bcnt);
        check("lsr0_lat", lat, 1);
        check("lsr0_o", o, 16'h1234);
        check("lsr0_fc", fC, 1'b0);

        do_op(4'd5, 16'hF0F0, 16'hFF00, 0, lat, bcnt);
        check("xor_o", o, 16'h0FF0);
        do_op(4'd4, 16'hFFFF, 16'h0000, 0, lat, bcnt);
        check("not_flags", {fZ, fC, fN, fE, fV}, 5'b10010);

        do_op(4'd1, 16'h0000, 16'h0001, 0, lat, bcnt);
        do_op(4'd12, 16'h0005, 16'h0006, 0, lat, bcnt);
        check("ill_lat", lat, 1);
        check("ill_o_flags", {o, fZ, fC, fN, fE, fV}, {16'h0, 5'b10010});
        do_op(4'd1, 16'h0000, 16'h0001, 0, lat, bcnt);
        do_op(4'd9, 16'h0005, 16'h0003, 0, lat, bcnt);
        check("sbc_o", o, 16'h0001);
        check("sbc_fc", fC, 1'b0);

`ifdef ALU_MC_MUL_EN
        do_op(4'd10, 16'h0100, 16'h0100, 0, lat, bcnt);
        check("mul1_lat", lat, 17);
        check("mul1_o_flags", {o, fZ, fC, fN, fE, fV}, {16'h0000, 5'b11011});
        do_op(4'd10, 16'h00FF, 16'h0101, 0, lat, bcnt);
        check("mul2_o", o, 16'hFFFF);
        check("mul2_fc", fC, 1'b0);
`else
        do_op(4'd10, 16'h0100, 16'h0100, 0, lat, bcnt);
        check("op10_lat", lat, 1);
        check("op10_o_flags", {o, fZ, fC, fN, fE, fV}, {16'h0000, 5'b10010});
`endif

        // start held through DONE is accepted again on the following IDLE cycle
        @(negedge clk); op = 4'd0; a = 16'h0001; b = 16'h0002; start = 1'b1;
        dcnt = 0;
        repeat (4) begin @(negedge clk); if (done === 1'b1) dcnt++; end
        start = 1'b0;
        check("held_start_dones", dcnt, 2);
        check("held_start_o", o, 16'h0003);

        // reset three cycles into a long operation
        @(negedge clk);
`ifdef ALU_MC_MUL_EN
        op = 4'd10; a = 16'h0100; b = 16'h0100;
`else
        op = 4'd7; a = 16'h8001; b = 16'h000F;
`endif
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_state", {busy, done, o, fZ}, {2'b00, 16'h0, 1'b1});
        dcnt = 0;
        repeat (20) begin @(negedge clk); if (done === 1'b1) dcnt++; end
        check("abort_no_done", dcnt, 0);

        do_op(4'd0, 16'h0002, 16'h0003, 0, lat, bcnt);
        check("post_rst_add_lat", lat, 1);
        check("post_rst_add_o", {o, fZ, fC, fN, fE, fV}, {16'h0005, 5'b00000});

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
